// File: rtl/tx_serial_8n1.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit; each bit held CLKS_PER_BIT cycles.
// Start bit appears at the accept edge; requests while busy are dropped (no queueing), caller waits for ocupado=0.
module tx_serial_8n1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados_ascii,
  output logic       saida_serial,
  output logic       pronto,
  output logic       ocupado,
  output logic [1:0] db_estado,
  output logic       db_tick
);

  localparam logic [1:0] INICIAL     = 2'b00;
  localparam logic [1:0] TRANSMISSAO = 2'b01;
  localparam logic [1:0] FINAL       = 2'b10;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       estado;
  logic [3:0]       bitIdx;
  logic [CNT_W-1:0] periodCnt;
  // Bits still to be shifted out after the one on the line; the start bit goes straight to the output register.
  logic [8:0]       shiftReg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado       <= INICIAL;
      saida_serial <= 1'b1;
      pronto       <= 1'b0;
      ocupado      <= 1'b0;
      db_tick      <= 1'b0;
      bitIdx       <= '0;
      periodCnt    <= '0;
      shiftReg     <= '1;
    end else begin
      pronto  <= 1'b0;
      db_tick <= 1'b0;
      case (estado)
        TRANSMISSAO: begin
          if (periodCnt == LAST_CNT) begin
            periodCnt <= '0;
            db_tick   <= 1'b1;
            if (bitIdx == 4'd9) begin
              estado       <= FINAL;
              saida_serial <= 1'b1;
              ocupado      <= 1'b0;
              pronto       <= 1'b1;
              shiftReg     <= '1;
            end else begin
              saida_serial <= shiftReg[0];
              shiftReg     <= {1'b1, shiftReg[8:1]};
              bitIdx       <= bitIdx + 4'd1;
            end
          end else begin
            periodCnt <= periodCnt + CNT_ONE;
          end
        end
        default: begin
          // The edge leaving the single final cycle already counts as idle, so a held
          // request restarts with exactly one idle-high cycle after the stop bit.
          estado       <= INICIAL;
          saida_serial <= 1'b1;
          if (partida) begin
            shiftReg     <= {1'b1, dados_ascii};
            saida_serial <= 1'b0;
            periodCnt    <= '0;
            bitIdx       <= '0;
            ocupado      <= 1'b1;
            estado       <= TRANSMISSAO;
          end
        end
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_tx_serial_8n1.sv
// Directed bench for tx_serial_8n1: fast instance (4 clocks/bit) plus a default-parameter instance.
module tb_tx_serial_8n1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, partida, saida, pronto, ocupado, dbTick;
  logic [7:0] dados;
  logic [1:0] dbEstado;

  logic       reset2, partida2, saida2, pronto2, ocupado2, dbTick2;
  logic [7:0] dados2;
  logic [1:0] dbEstado2;

  tx_serial_8n1 #(.CLKS_PER_BIT(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .partida(partida), .dados_ascii(dados),
    .saida_serial(saida), .pronto(pronto), .ocupado(ocupado),
    .db_estado(dbEstado), .db_tick(dbTick)
  );

  tx_serial_8n1 dutDefault (
    .clock(clock), .reset(reset2), .partida(partida2), .dados_ascii(dados2),
    .saida_serial(saida2), .pronto(pronto2), .ocupado(ocupado2),
    .db_estado(dbEstado2), .db_tick(dbTick2)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  logic expBits[$];
  int   prontoCyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic pushFrame(input logic [7:0] d);
    expBits.push_back(1'b0);
    for (int i = 0; i < 8; i++) expBits.push_back(d[i]);
    expBits.push_back(1'b1);
  endtask

  // Starts at the negedge after the accept edge, ends at the negedge after the pronto edge.
  task automatic watchFrame(input int pokeAt, input logic [7:0] pokeData, input int dropAt);
    logic e;
    int   k;
    for (int b = 0; b < 10; b++) begin
      e = expBits.pop_front();
      for (int c = 0; c < 4; c++) begin
        k = b * 4 + c;
        if (k == pokeAt) begin
          partida = 1'b1;
          dados   = pokeData;
        end
        if (pokeAt >= 0 && k == pokeAt + 1) partida = 1'b0;
        if (k == dropAt) partida = 1'b0;
        chk("line", saida, e);
        chk("busy", ocupado, 1);
        chk("prontoLow", pronto, 0);
        chk("tick", dbTick, (c == 0 && b > 0));
        chk("estadoTx", dbEstado, 2'b01);
        step();
      end
    end
    chk("prontoPulse", pronto, 1);
    chk("busyEnd", ocupado, 0);
    chk("lineStop", saida, 1);
    chk("estadoFinal", dbEstado, 2'b10);
    chk("tickLast", dbTick, 1);
    prontoCyc = cyc;
  endtask

  initial begin
    int   acceptCyc, firstStart, p1, ticks;
    logic e;

    reset = 1'b0; partida = 1'b0; dados = 8'h00;
    reset2 = 1'b0; partida2 = 1'b0; dados2 = 8'h00;
    repeat (3) step();
    chk("rstLine", saida, 1);
    chk("rstPronto", pronto, 0);
    chk("rstBusy", ocupado, 0);
    chk("rstEstado", dbEstado, 2'b00);
    chk("rstTick", dbTick, 0);
    chk("rstLine2", saida2, 1);
    reset = 1'b1; reset2 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idleLine", saida, 1);
      chk("idlePronto", pronto, 0);
      chk("idleBusy", ocupado, 0);
      chk("idleEstado", dbEstado, 2'b00);
    end

    // Single byte 0x35, one-cycle request; data changed right after accept
    partida = 1'b1; dados = 8'h35; pushFrame(8'h35);
    step();
    partida = 1'b0; dados = 8'h00; acceptCyc = cyc;
    watchFrame(-1, 8'h00, -1);
    chk("prontoLatency", prontoCyc - acceptCyc, 40);
    step();
    chk("backIdleEstado", dbEstado, 2'b00);
    chk("backIdlePronto", pronto, 0);
    chk("backIdleLine", saida, 1);

    // Request with 0xFF at cycle 12 of an 0xA5 frame is ignored
    partida = 1'b1; dados = 8'hA5; pushFrame(8'hA5);
    step();
    partida = 1'b0;
    watchFrame(12, 8'hFF, -1);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("noSecondPronto", pronto, 0);
      chk("noSecondFrame", saida, 1);
      chk("noSecondBusy", ocupado, 0);
    end
    chk("queueEmpty", expBits.size(), 0);

    // Back-to-back: 0x00 then 0xFF with partida held high
    partida = 1'b1; dados = 8'h00; pushFrame(8'h00);
    step();
    firstStart = cyc;
    dados = 8'hFF; pushFrame(8'hFF);
    watchFrame(-1, 8'h00, -1);
    p1 = prontoCyc;
    step();
    chk("startSpacing", cyc - firstStart, 41);
    watchFrame(-1, 8'h00, 2);
    chk("prontoSpacing", prontoCyc - p1, 41);
    step();
    chk("b2bIdleEstado", dbEstado, 2'b00);
    chk("b2bIdleLine", saida, 1);
    chk("b2bIdlePronto", pronto, 0);

    // Reset at cycle 17 of a 0xC3 frame, then a clean 0x96 frame
    step();
    partida = 1'b1; dados = 8'hC3; pushFrame(8'hC3);
    step();
    partida = 1'b0;
    e = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k % 4 == 0) e = expBits.pop_front();
      chk("preResetLine", saida, e);
      step();
    end
    reset = 1'b0;
    step();
    chk("midRstLine", saida, 1);
    chk("midRstPronto", pronto, 0);
    chk("midRstEstado", dbEstado, 2'b00);
    chk("midRstBusy", ocupado, 0);
    expBits.delete();
    step();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("postRstPronto", pronto, 0);
      chk("postRstLine", saida, 1);
    end
    partida = 1'b1; dados = 8'h96; pushFrame(8'h96);
    step();
    partida = 1'b0;
    watchFrame(-1, 8'h00, -1);
    step();

    // Default parameter instance, 0x5A
    partida2 = 1'b1; dados2 = 8'h5A; pushFrame(8'h5A);
    step();
    partida2 = 1'b0; acceptCyc = cyc; ticks = 0;
    for (int k = 0; k < 4340; k++) begin
      if (k % 434 == 0) e = expBits.pop_front();
      chk("dfltLine", saida2, e);
      chk("dfltTick", dbTick2, (k % 434 == 0 && k > 0));
      if (dbTick2) ticks++;
      if (k % 434 == 217) begin
        chk("dfltPronto", pronto2, 0);
        chk("dfltBusy", ocupado2, 1);
      end
      step();
    end
    chk("dfltProntoPulse", pronto2, 1);
    chk("dfltBusyEnd", ocupado2, 0);
    if (dbTick2) ticks++;
    chk("dfltTickCount", ticks, 10);
    chk("dfltFrameLen", cyc - acceptCyc, 4340);
    step();
    chk("dfltProntoOff", pronto2, 0);
    chk("dfltEstadoIdle", dbEstado2, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
